mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one SRAM-style bus between instruction fetch (IF) and the mem stage (DM).
//  Sits between the pipeline and the external memory bus.
//  - Latches the winner's request and holds it stable until bus ack.
//  - Returns read data with a one-cycle valid pulse; stalls the losing/waiting requester.
//  - DM has priority; a starvation counter guarantees IF progress.
// PARAMETERS
//  STARVE_MAX      4    consecutive DM grants while IF waits before IF is forced in
//  TIMEOUT_CYCLES  255  ack wait limit (only with ARB_BUS_TIMEOUT_EN), 8-bit counter
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   asynchronous, active-low reset
//  flush_i      in   1   pipeline flush; cancels the IF request
//  if_req_i     in   1   IF read request, held until if_valid_o
//  if_addr_i    in   32  IF word address
//  if_rdata_o   out  32  fetched word, valid with if_valid_o
//  if_valid_o   out  1   1-cycle pulse: IF access done
//  if_stall_o   out  1   if_req_i & ~if_valid_o (combinational)
//  dm_req_i     in   1   DM request (mem stage chip enable), held until dm_valid_o
//  dm_we_i      in   1   1 = store
//  dm_sel_i     in   4   byte lanes, [3] = addr[1:0]==0 (big-lane order of mem stage)
//  dm_addr_i    in   32  DM address
//  dm_wdata_i   in   32  store data, lane-replicated by mem stage
//  dm_rdata_o   out  32  load word, valid with dm_valid_o
//  dm_valid_o   out  1   1-cycle pulse: DM access done
//  dm_stall_o   out  1   dm_req_i & ~dm_valid_o (combinational)
//  bus_req_o    out  1   bus request, held high until bus_ack_i
//  bus_we_o     out  1   bus write enable
//  bus_sel_o    out  4   bus byte select (IF drives 4'b1111)
//  bus_addr_o   out  32  bus address
//  bus_wdata_o  out  32  bus write data (0 for IF)
//  bus_rdata_i  in   32  bus read data, sampled on ack
//  bus_ack_i    in   1   bus completion, one cycle
//  bus_err_o    out  1   1-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset: state IDLE, starve counter 0, all outputs 0, including bus_req_o
//    (asynchronous drop even mid-transfer; the bus must tolerate an abandoned request).
//  - States: IDLE, IF_BUSY, DM_BUSY, IF_DRAIN.
//  - IDLE:
//    - dm_req_i & (starve<STARVE_MAX | ~if_req_i | flush_i) -> DM_BUSY.
//    - Else if_req_i & ~flush_i -> IF_BUSY.
//    - Winner's addr/we/sel/wdata registered onto bus_* with bus_req_o=1 next cycle.
//  - *_BUSY: bus_* held constant; on bus_ack_i -> IDLE.
//    - rdata registered; matching *_valid_o high the following cycle.
//  - Latency: req in IDLE at cycle t -> bus_req_o at t+1 -> ack at t+1+k -> valid at t+2+k.
//    Minimum is 2 cycles (k=0).
//  - No bus grant in the cycle a valid pulses; the requester drops or changes its request.
//  - Starve counter:
//    - +1 (saturating) on each DM grant while if_req_i=1.
//    - Cleared on IF grant or when if_req_i=0.
//  - Flush:
//    - In IF_BUSY: -> IF_DRAIN; bus request still held until ack, if_valid_o suppressed.
//    - In IDLE: IF is not granted that cycle.
//    - DM transfers are never cancelled.
//  - Store: dm_valid_o pulses on completion; dm_rdata_o unchanged.
//  - Simultaneous ack and flush in IF_BUSY: completes to IDLE, no if_valid_o.
// CONFIGURATION
//  ARB_BUS_TIMEOUT_EN defined:
//    - Wait counter cleared on entry to each BUSY/DRAIN state.
//    - On reaching TIMEOUT_CYCLES with no ack: bus_req_o drops and the block returns to IDLE.
//    - bus_err_o pulses 1 cycle; the owner's *_valid_o pulses with rdata=0 (none for DRAIN).
//  Undefined: no counter, bus_err_o tied 0, waits for ack indefinitely.
// TESTING
//  1. IF read 0x1C00_0000, ack after 3 cycles, rdata 0xDEADBEEF -> if_valid_o 1 cycle, rdata matches.
//  2. IF and DM (store, sel 4'b0100, addr 0x101) in same cycle -> DM first, bus_we_o=1; IF follows.
//  3. DM requests back-to-back, IF pending -> IF granted after 4 DM grants (STARVE_MAX=4).
//  4. flush_i during IF_BUSY, ack 2 cycles later -> no if_valid_o, next grant after ack.
//  5. Reset asserted mid DM_BUSY -> bus_req_o=0 immediately, state IDLE, no valid pulse.
//  6. With ARB_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> bus_err_o pulse at cycle 8, dm_valid_o, rdata 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-style bus between instruction fetch (IF)
// and the mem stage (DM).
//   - DM has priority.
//   - A starvation counter forces IF in after STARVE_MAX consecutive DM grants.
//   - The winner's request is registered onto bus_* and held until bus_ack_i.
//   - Completion is reported with a one-cycle *_valid_o pulse.
// Optional feature: define ARB_BUS_TIMEOUT_EN to abort a transfer that waits
// TIMEOUT_CYCLES without an ack. The abort pulses bus_err_o.
module mem_bus_arbiter #(
    parameter int STARVE_MAX = 4
`ifdef ARB_BUS_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active low
    input  logic        flush_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        if_stall_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_sel_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_valid_o,
    output logic        dm_stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IF_BUSY  = 2'd1;
    localparam logic [1:0] DM_BUSY  = 2'd2;
    localparam logic [1:0] IF_DRAIN = 2'd3;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [1:0]  state_q, state_d;
    logic [7:0]  starve_q, starve_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic        dm_valid_q, dm_valid_d;
`ifdef ARB_BUS_TIMEOUT_EN
    logic [7:0]  wait_q, wait_d;
    logic        bus_err_q, bus_err_d;
`endif

    logic valid_pulse, grant_dm, grant_if;

    // Grant decision. Nothing is granted while a valid pulse is out, because the
    // requester still holds its old request during that cycle.
    always_comb begin
        valid_pulse = if_valid_q | dm_valid_q;
        grant_dm    = (state_q == IDLE) & ~valid_pulse & dm_req_i &
                      ((starve_q < STARVE_LIM) | ~if_req_i | flush_i);
        grant_if    = (state_q == IDLE) & ~valid_pulse & ~grant_dm &
                      if_req_i & ~flush_i;
    end

    // Starvation counter: counts DM grants that happen while IF is waiting.
    // It saturates at STARVE_MAX.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || grant_if)
            starve_d = '0;
        else if (grant_dm && (starve_q < STARVE_LIM))
            starve_d = starve_q + 8'd1;
    end

    // Transfer FSM: latch the winner onto the bus, hold it until ack, then return data.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d     = DM_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = dm_we_i;
                    bus_sel_d   = dm_sel_i;
                    bus_addr_d  = dm_addr_i;
                    bus_wdata_d = dm_wdata_i;
                end else if (grant_if) begin
                    state_d     = IF_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = 4'b1111;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = '0;
                end
            end
            IF_BUSY: begin
                if (bus_ack_i) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    // A flush in the completing cycle discards the fetched word.
                    if (!flush_i) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus_rdata_i;
                    end
                end else if (flush_i) begin
                    state_d = IF_DRAIN;
                end
            end
            DM_BUSY: begin
                if (bus_ack_i) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    dm_valid_d = 1'b1;
                    if (!bus_we_q)
                        dm_rdata_d = bus_rdata_i;
                end
            end
            default: begin  // IF_DRAIN: wait out the cancelled fetch silently
                if (bus_ack_i) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                end
            end
        endcase
`ifdef ARB_BUS_TIMEOUT_EN
        bus_err_d = 1'b0;
        wait_d    = wait_q;
        if (state_q == IDLE) begin
            wait_d = '0;
        end else if (!bus_ack_i) begin
            if (wait_q == 8'(TIMEOUT_CYCLES - 1)) begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
                bus_err_d = 1'b1;
                wait_d    = '0;
                if (state_q == IF_BUSY && !flush_i) begin
                    if_valid_d = 1'b1;
                    if_rdata_d = '0;
                end
                if (state_q == DM_BUSY) begin
                    dm_valid_d = 1'b1;
                    dm_rdata_d = '0;
                end
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
`endif
    end

    // State registers. Reset drops bus_req_o at once, even in the middle of a transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
`ifdef ARB_BUS_TIMEOUT_EN
            wait_q      <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
`ifdef ARB_BUS_TIMEOUT_EN
            wait_q      <= wait_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign if_stall_o  = if_req_i & ~if_valid_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_valid_o  = dm_valid_q;
    assign dm_stall_o  = dm_req_i & ~dm_valid_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
`ifdef ARB_BUS_TIMEOUT_EN
    assign bus_err_o   = bus_err_q;
`else
    assign bus_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (default build, STARVE_MAX = 4).
// Inputs are driven and outputs are sampled on the falling clock edge.
// Expected read data is queued per requester when a request is issued,
// and popped when the matching valid pulse appears.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_valid_o, if_stall_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [3:0]  dm_sel_i = '0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        dm_valid_o, dm_stall_o;
    logic        bus_req_o, bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        bus_err_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] if_exp[$];
    logic [31:0] dm_exp[$];

    mem_bus_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o),
        .dm_valid_o(dm_valid_o), .dm_stall_o(dm_stall_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for bus_req_o and check how many cycles that took.
    task automatic wait_req(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_req_o !== 1'b1 && n < 20);
        chk({tag, "_latency"}, 32'(n), 32'(exp_n));
    endtask

    // Hold the bus for k more cycles, then ack once with the given read data.
    task automatic ack_after(input int k, input logic [31:0] rd);
        logic [31:0] a;
        a = bus_addr_o;
        repeat (k) begin
            @(negedge clk);
            chk("hold_req", 32'(bus_req_o), 32'd1);
            chk("hold_addr", bus_addr_o, a);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = rd;
        @(negedge clk);
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
    endtask

    task automatic expect_if(input string tag);
        logic [31:0] e;
        e = (if_exp.size() > 0) ? if_exp.pop_front() : 32'hBAD0_BAD0;
        chk({tag, "_if_valid"}, 32'(if_valid_o), 32'd1);
        chk({tag, "_if_rdata"}, if_rdata_o, e);
        chk({tag, "_if_stall_released"}, 32'(if_stall_o), 32'd0);
    endtask

    task automatic expect_dm(input string tag);
        logic [31:0] e;
        e = (dm_exp.size() > 0) ? dm_exp.pop_front() : 32'hBAD0_BAD0;
        chk({tag, "_dm_valid"}, 32'(dm_valid_o), 32'd1);
        chk({tag, "_dm_rdata"}, dm_rdata_o, e);
        chk({tag, "_dm_stall_released"}, 32'(dm_stall_o), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_if_valid", 32'(if_valid_o), 32'd0);
        chk("rst_dm_valid", 32'(dm_valid_o), 32'd0);
        chk("rst_bus_err", 32'(bus_err_o), 32'd0);
        chk("rst_rdata", if_rdata_o | dm_rdata_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // IF read, ack three cycles after the request appears
        if_req_i = 1'b1; if_addr_i = 32'h1C00_0000;
        if_exp.push_back(32'hDEAD_BEEF);
        #1 chk("t1_if_stall", 32'(if_stall_o), 32'd1);
        wait_req("t1_req", 1);
        chk("t1_addr", bus_addr_o, 32'h1C00_0000);
        chk("t1_we", 32'(bus_we_o), 32'd0);
        chk("t1_sel", 32'(bus_sel_o), 32'hF);
        chk("t1_wdata", bus_wdata_o, 32'd0);
        ack_after(3, 32'hDEAD_BEEF);
        expect_if("t1");
        if_req_i = 1'b0;
        @(negedge clk);
        chk("t1_pulse_once", 32'(if_valid_o), 32'd0);

        // IF and DM store in the same cycle: DM goes first, IF follows
        if_req_i = 1'b1; if_addr_i = 32'h0000_0400;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b0100;
        dm_addr_i = 32'h0000_0101; dm_wdata_i = 32'hA5A5_A5A5;
        dm_exp.push_back(32'h0);          // a store leaves dm_rdata_o untouched
        if_exp.push_back(32'h1234_5678);
        wait_req("t2_dm_req", 1);
        chk("t2_addr", bus_addr_o, 32'h0000_0101);
        chk("t2_we", 32'(bus_we_o), 32'd1);
        chk("t2_sel", 32'(bus_sel_o), 32'h4);
        chk("t2_wdata", bus_wdata_o, 32'hA5A5_A5A5);
        chk("t2_if_stall", 32'(if_stall_o), 32'd1);
        ack_after(0, 32'hFFFF_0000);
        expect_dm("t2");
        chk("t2_no_if_valid", 32'(if_valid_o), 32'd0);
        dm_req_i = 1'b0; dm_we_i = 1'b0;
        wait_req("t2_if_req", 2);         // no grant in the valid cycle
        chk("t2_if_addr", bus_addr_o, 32'h0000_0400);
        chk("t2_if_we", 32'(bus_we_o), 32'd0);
        chk("t2_if_sel", 32'(bus_sel_o), 32'hF);
        ack_after(1, 32'h1234_5678);
        expect_if("t2");
        if_req_i = 1'b0;
        @(negedge clk);

        // back-to-back DM loads with IF pending: IF wins after four DM grants
        if_req_i = 1'b1; if_addr_i = 32'h0000_0800;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h0000_2000;
        if_exp.push_back(32'hCAFE_0000);
        for (int i = 0; i < 4; i++) begin
            dm_exp.push_back(32'h0000_1000 + 32'(i));
            wait_req("t3_dm_req", (i == 0) ? 1 : 2);
            chk("t3_dm_addr", bus_addr_o, 32'h0000_2000 + 32'(4 * i));
            ack_after(0, 32'h0000_1000 + 32'(i));
            expect_dm("t3");
            dm_addr_i = 32'h0000_2000 + 32'(4 * (i + 1));
        end
        wait_req("t3_if_req", 2);
        chk("t3_if_forced", bus_addr_o, 32'h0000_0800);
        ack_after(0, 32'hCAFE_0000);
        expect_if("t3");
        if_req_i = 1'b0;
        dm_exp.push_back(32'h0000_2222);
        wait_req("t3_dm_after", 2);
        chk("t3_dm_after_addr", bus_addr_o, 32'h0000_2010);
        ack_after(0, 32'h0000_2222);
        expect_dm("t3b");
        dm_req_i = 1'b0;
        @(negedge clk);

        // flush during IF_BUSY, ack two cycles later: drained silently, then refetch
        if_req_i = 1'b1; if_addr_i = 32'h0000_0900;
        wait_req("t4_req", 1);
        flush_i = 1'b1; if_addr_i = 32'h0000_0980;
        @(negedge clk);
        flush_i = 1'b0;
        chk("t4_req_held", 32'(bus_req_o), 32'd1);
        chk("t4_addr_held", bus_addr_o, 32'h0000_0900);
        @(negedge clk);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
        @(negedge clk);
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        chk("t4_no_if_valid", 32'(if_valid_o), 32'd0);
        chk("t4_req_dropped", 32'(bus_req_o), 32'd0);
        if_exp.push_back(32'h1357_9BDF);
        wait_req("t4_refetch", 1);
        chk("t4_refetch_addr", bus_addr_o, 32'h0000_0980);
        ack_after(0, 32'h1357_9BDF);
        expect_if("t4");
        if_req_i = 1'b0;
        @(negedge clk);

        // ack and flush in the same cycle: completes, no valid pulse
        if_req_i = 1'b1; if_addr_i = 32'h0000_0A00;
        wait_req("t4b_req", 1);
        flush_i = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0077;
        @(negedge clk);
        flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0; if_req_i = 1'b0;
        chk("t4b_no_if_valid", 32'(if_valid_o), 32'd0);
        chk("t4b_bus_idle", 32'(bus_req_o), 32'd0);
        @(negedge clk);
        chk("t4b_still_no_valid", 32'(if_valid_o), 32'd0);

        // reset in the middle of a DM transfer
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_3000;
        wait_req("t5_req", 1);
        @(negedge clk);
        chk("t5_busy", 32'(bus_req_o), 32'd1);
        #2 rst = 1'b0;
        #1 chk("t5_req_async_drop", 32'(bus_req_o), 32'd0);
        chk("t5_no_dm_valid", 32'(dm_valid_o), 32'd0);
        @(negedge clk);
        dm_req_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_dm_valid_after", 32'(dm_valid_o), 32'd0);
        chk("t5_dm_rdata_cleared", dm_rdata_o, 32'd0);
        if_req_i = 1'b1; if_addr_i = 32'h0000_0B00;
        if_exp.push_back(32'h0000_600D);
        wait_req("t5_post_req", 1);
        chk("t5_post_addr", bus_addr_o, 32'h0000_0B00);
        ack_after(0, 32'h0000_600D);
        expect_if("t5");
        if_req_i = 1'b0;
        @(negedge clk);

        chk("sb_if_drained", 32'(if_exp.size()), 32'd0);
        chk("sb_dm_drained", 32'(dm_exp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
